btpipe_out_arbiter: RTL and testbench

//  Shares one okBTPipeOut endpoint among N_CH data sources at block granularity.

---
 rtl/btpipe_arb_pkg.sv | 16 +
 rtl/btpipe_out_arbiter_rr_select.sv | 28 ++
 rtl/btpipe_out_arbiter.sv | 110 +++++++++++
 tb/tb_btpipe_out_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btpipe_arb_pkg.sv
// Shared constants for the block-granular okBTPipeOut arbiter: header tag,
// FSM state encodings and the header word builder.
package btpipe_arb_pkg;

  localparam logic [7:0] HDR_TAG = 8'hA5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_HEADER  = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  function automatic logic [15:0] hdr_word(input logic [3:0] ch);
    return {HDR_TAG, 4'h0, ch};
  endfunction

endpackage

// File: rtl/btpipe_out_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
module rr_select #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [3:0]      ptr,
  output logic            valid,
  output logic [3:0]      idx
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [4:0]        sum;

  always_comb begin
    dbl   = {req, req};
    rot   = N_CH'(dbl >> ptr);
    valid = |req;
    sum   = {1'b0, ptr};
    // Scan downward so the lowest rotated position (nearest ptr) wins.
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (rot[j]) sum = {1'b0, ptr} + 5'(j);
    end
    if (sum >= 5'(N_CH)) sum = sum - 5'(N_CH);
    idx = sum[3:0];
  end

endmodule

// File: rtl/btpipe_out_arbiter.sv
// Shares one okBTPipeOut among N_CH FWFT sources, one header-tagged block per
// round-robin grant; all logic in the ti_clk domain.
module btpipe_out_arbiter
  import btpipe_arb_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 9
) (
  input  logic                 ti_clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 err_clr,
  input  logic                 ep_read,
  input  logic                 ep_blockstrobe,
  output logic [15:0]          ep_datain,
  output logic                 ep_ready,
  input  logic [N_CH-1:0]      ch_ready,
  input  logic [16*N_CH-1:0]   ch_data,
  output logic [N_CH-1:0]      ch_rd,
  output logic [3:0]           grant_ch,
  output logic                 busy,
  output logic                 err
);

  logic [1:0]       state;
  logic [3:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic             sel_valid;
  logic [3:0]       sel_idx;
  logic             err_set;

  rr_select #(.N_CH(N_CH)) u_rr (
    .req   (ch_ready),
    .ptr   (ptr),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  assign busy = (state == ST_HEADER) || (state == ST_PAYLOAD);

  // Reads outside a block and strobes anywhere but ARMED are protocol errors.
  assign err_set = (ep_read && !busy) || (ep_blockstrobe && (state != ST_ARMED));

  always_comb begin
    ep_datain = '0;
    ch_rd     = '0;
    case (state)
      ST_HEADER:  ep_datain = hdr_word(grant_ch);
      ST_PAYLOAD: begin
        for (int i = 0; i < N_CH; i++) begin
          if (grant_ch == 4'(i)) begin
            ep_datain = ch_data[16*i +: 16];
            ch_rd[i]  = ep_read && !ep_blockstrobe;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_ch <= '0;
      cnt      <= '0;
      ep_ready <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= err_set || (err && !err_clr);
      case (state)
        ST_IDLE: begin
          if (enable && sel_valid) begin
            grant_ch <= sel_idx;
            ptr      <= (sel_idx == 4'(N_CH - 1)) ? 4'd0 : sel_idx + 4'd1;
            ep_ready <= 1'b1;
            state    <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (ep_blockstrobe) begin
            cnt      <= '0;
            ep_ready <= 1'b0;
            state    <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (ep_blockstrobe) begin
            cnt <= '0;
          end else if (ep_read) begin
            cnt   <= CNT_W'(1);
            state <= ST_PAYLOAD;
          end
        end
        default: begin
          // A restart strobe abandons the block; already-popped words are lost.
          if (ep_blockstrobe) begin
            cnt   <= '0;
            state <= ST_HEADER;
          end else if (ep_read) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(BLOCK_WORDS - 1)) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btpipe_out_arbiter.sv
// Scoreboard bench for btpipe_out_arbiter: sources are counters tagged with
// their channel number; expected block contents are queued at strobe time.
module tb_btpipe_out_arbiter;

  localparam int N_CH = 4;
  localparam int BW   = 256;

  logic              ti_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              err_clr = 1'b0;
  logic              ep_read = 1'b0;
  logic              ep_blockstrobe = 1'b0;
  logic [15:0]       ep_datain;
  logic              ep_ready;
  logic [N_CH-1:0]   ch_ready = '0;
  logic [16*N_CH-1:0] ch_data;
  logic [N_CH-1:0]   ch_rd;
  logic [3:0]        grant_ch;
  logic              busy;
  logic              err;

  int nvec = 0;
  int nmis = 0;

  logic [11:0] rd_seq [N_CH];
  int          rd_cnt [N_CH];

  typedef struct {
    logic [15:0] d;
    logic        hdr;
  } exp_t;
  exp_t exp_q[$];

  btpipe_out_arbiter #(.N_CH(N_CH), .BLOCK_WORDS(BW), .CNT_W(9)) dut (
    .ti_clk         (ti_clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .err_clr        (err_clr),
    .ep_read        (ep_read),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_datain      (ep_datain),
    .ep_ready       (ep_ready),
    .ch_ready       (ch_ready),
    .ch_data        (ch_data),
    .ch_rd          (ch_rd),
    .grant_ch       (grant_ch),
    .busy           (busy),
    .err            (err)
  );

  always #5 ti_clk = ~ti_clk;

  for (genvar i = 0; i < N_CH; i++) begin : g_src
    assign ch_data[16*i +: 16] = {4'(i), rd_seq[i]};
  end

  // Pops the FWFT source models and polices ch_rd on every edge.
  always @(posedge ti_clk) begin
    if (ch_rd != '0) begin
      nvec++;
      if ($countones(ch_rd) != 1 || ch_rd != (N_CH'(1) << grant_ch) || !busy) begin
        nmis++;
        $display("FAIL ch_rd_onehot: ch_rd=%b grant=%0d busy=%b, want single bit on grant while busy",
                 ch_rd, grant_ch, busy);
      end
      for (int i = 0; i < N_CH; i++) begin
        if (ch_rd[i]) begin
          rd_seq[i] <= rd_seq[i] + 12'd1;
          rd_cnt[i] <= rd_cnt[i] + 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge ti_clk);
    #1;
  endtask

  task automatic do_reset;
    enable = 1'b0; err_clr = 1'b0; ep_read = 1'b0; ep_blockstrobe = 1'b0; ch_ready = '0;
    tick;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_armed(input int g, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ep_ready && n < 8) begin
      tick;
      n++;
    end
    nvec++;
    if (!ep_ready) begin
      nmis++;
      $display("FAIL arm_timeout: ep_ready=%b after %0d cycles, want 1", ep_ready, n);
      return;
    end
    nvec++;
    if (grant_ch !== 4'(g)) begin
      nmis++;
      $display("FAIL grant: got %0d, want %0d", grant_ch, g);
    end
    ok = 1'b1;
  endtask

  task automatic do_strobe(input int g);
    exp_t e;
    ep_blockstrobe = 1'b1;
    e.d = {8'hA5, 4'h0, 4'(g)};
    e.hdr = 1'b1;
    exp_q.push_back(e);
    for (int k = 1; k < BW; k++) begin
      e.d   = {4'(g), rd_seq[g] + 12'(k - 1)};
      e.hdr = 1'b0;
      exp_q.push_back(e);
    end
    tick;
    ep_blockstrobe = 1'b0;
    nvec++;
    if (ep_ready !== 1'b0 || busy !== 1'b1) begin
      nmis++;
      $display("FAIL strobe_state: ep_ready=%b busy=%b, want 0 1", ep_ready, busy);
    end
  endtask

  task automatic read_words(input int g, input int n);
    exp_t e;
    logic [N_CH-1:0] exp_rd;
    for (int i = 0; i < n; i++) begin
      ep_read = 1'b1;
      #1;
      if (exp_q.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL scoreboard_empty: read %0d has no expected word", i);
        break;
      end
      e = exp_q.pop_front();
      exp_rd = e.hdr ? '0 : (N_CH'(1) << g);
      nvec++;
      if (ep_datain !== e.d) begin
        nmis++;
        $display("FAIL word: read %0d got %h, want %h", i, ep_datain, e.d);
      end
      nvec++;
      if (ch_rd !== exp_rd) begin
        nmis++;
        $display("FAIL ch_rd: read %0d got %b, want %b", i, ch_rd, exp_rd);
      end
      tick;
    end
    ep_read = 1'b0;
  endtask

  task automatic run_block(input int g);
    bit ok;
    int c0;
    c0 = rd_cnt[g];
    wait_armed(g, ok);
    if (!ok) return;
    do_strobe(g);
    read_words(g, BW);
    nvec++;
    if (ep_ready !== 1'b0 || busy !== 1'b0) begin
      nmis++;
      $display("FAIL block_end: ep_ready=%b busy=%b, want 0 0", ep_ready, busy);
    end
    nvec++;
    if (rd_cnt[g] - c0 != BW - 1) begin
      nmis++;
      $display("FAIL pop_count: ch%0d popped %0d, want %0d", g, rd_cnt[g] - c0, BW - 1);
    end
  endtask

  task automatic test_reset;
    #2;
    nvec++;
    if (ep_ready !== 1'b0 || ch_rd !== '0 || ep_datain !== 16'h0 ||
        grant_ch !== 4'h0 || busy !== 1'b0 || err !== 1'b0) begin
      nmis++;
      $display("FAIL reset: ep_ready=%b ch_rd=%b data=%h grant=%0d busy=%b err=%b, want all 0",
               ep_ready, ch_rd, ep_datain, grant_ch, busy, err);
    end
  endtask

  task automatic test_single;
    do_reset;
    ch_ready = 4'b0001;
    enable = 1'b1;
    tick;
    nvec++;
    if (ep_ready !== 1'b1) begin
      nmis++;
      $display("FAIL arm_latency: ep_ready=%b one cycle after enable, want 1", ep_ready);
    end
    run_block(0);
  endtask

  task automatic test_round_robin;
    do_reset;
    ch_ready = 4'b1111;
    enable = 1'b1;
    for (int b = 0; b < 8; b++) run_block(b % N_CH);
  endtask

  task automatic test_wrap;
    do_reset;
    ch_ready = 4'b0100;
    enable = 1'b1;
    run_block(2);
    run_block(2);
    ch_ready = 4'b0101;
    run_block(0);
    run_block(2);
  endtask

  task automatic test_err_read;
    do_reset;
    tick;
    ep_read = 1'b1;
    #1;
    nvec++;
    if (ch_rd !== '0 || ep_datain !== 16'h0) begin
      nmis++;
      $display("FAIL idle_read: ch_rd=%b data=%h, want 0 0", ch_rd, ep_datain);
    end
    tick;
    ep_read = 1'b0;
    nvec++;
    if (err !== 1'b1) begin nmis++; $display("FAIL err_set: err=%b, want 1", err); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    nvec++;
    if (err !== 1'b0) begin nmis++; $display("FAIL err_clr: err=%b, want 0", err); end
    err_clr = 1'b1;
    ep_read = 1'b1;
    tick;
    err_clr = 1'b0;
    ep_read = 1'b0;
    nvec++;
    if (err !== 1'b1) begin nmis++; $display("FAIL err_set_wins: err=%b, want 1", err); end
  endtask

  task automatic test_restart;
    bit ok;
    int c0;
    do_reset;
    ch_ready = 4'b0001;
    enable = 1'b1;
    c0 = rd_cnt[0];
    wait_armed(0, ok);
    if (!ok) return;
    do_strobe(0);
    read_words(0, 11);
    nvec++;
    if (err !== 1'b0) begin nmis++; $display("FAIL err_pre_restart: err=%b, want 0", err); end
    exp_q.delete();
    do_strobe(0);
    nvec++;
    if (err !== 1'b1) begin nmis++; $display("FAIL err_restart: err=%b, want 1", err); end
    read_words(0, BW);
    nvec++;
    if (ep_ready !== 1'b0 || busy !== 1'b0 || rd_cnt[0] - c0 != 10 + BW - 1) begin
      nmis++;
      $display("FAIL restart_end: ep_ready=%b busy=%b pops=%0d, want 0 0 %0d",
               ep_ready, busy, rd_cnt[0] - c0, 10 + BW - 1);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    do_reset;
    ch_ready = 4'b0010;
    enable = 1'b1;
    wait_armed(1, ok);
    if (!ok) return;
    do_strobe(1);
    read_words(1, 101);
    ep_read = 1'b1;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (ep_ready !== 1'b0 || ch_rd !== '0 || ep_datain !== 16'h0 ||
        grant_ch !== 4'h0 || busy !== 1'b0 || err !== 1'b0) begin
      nmis++;
      $display("FAIL async_reset: ep_ready=%b ch_rd=%b data=%h grant=%0d busy=%b err=%b, want all 0",
               ep_ready, ch_rd, ep_datain, grant_ch, busy, err);
    end
    ep_read = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_q.delete();
    ch_ready = 4'b1111;
    run_block(0);
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      rd_seq[i] = 12'h100 * 12'(i + 1);
      rd_cnt[i] = 0;
    end
    test_reset;
    test_single;
    test_round_robin;
    test_wrap;
    test_err_read;
    test_restart;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
